mul_arb_scheduler: RTL

MUL_ARB_SCHEDULER -- requirements
Module: mul_arb_scheduler

---
 rtl/mul_arb_scheduler_if.sv | 29 ++
 rtl/mul_arb_scheduler.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/mul_arb_scheduler_if.sv
// Signal bundle between two requesters, the multiplier scheduler and the shared multiplier.
interface mul_arb_scheduler_if;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]  req0_opcode, req0_precision, req1_opcode, req1_precision;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready, rsp1_ready;
  logic [31:0] rsp0_data, rsp1_data;
  logic [31:0] mul_operand_a, mul_operand_b, mul_result;
  logic [1:0]  mul_opcode, mul_precision;
  logic        busy;

  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
    output req0_opcode, req0_precision, req1_opcode, req1_precision,
    output rsp0_ready, rsp1_ready, mul_result,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_data, rsp1_data,
    input  mul_operand_a, mul_operand_b, mul_opcode, mul_precision, busy
  );

  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
    input  req0_opcode, req0_precision, req1_opcode, req1_precision,
    input  rsp0_ready, rsp1_ready, mul_result,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_data, rsp1_data,
    output mul_operand_a, mul_operand_b, mul_opcode, mul_precision, busy
  );
endinterface

// File: rtl/mul_arb_scheduler.sv
// Two-requester scheduler for one pipelined multiplier with credit-guarded per-requester response FIFOs.
// Define MUL_ARB_FIXED_PRIO_EN for fixed priority to req0; otherwise round-robin arbitration.
module mul_arb_scheduler #(
  parameter int MUL_LATENCY = 3,
  parameter int RSP_DEPTH   = 4
) (
  input logic                clk,
  input logic                rst,
  mul_arb_scheduler_if.slave bus
);
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(RSP_DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(RSP_DEPTH - 1);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_C) ? '0 : p + 1'b1;
  endfunction

  logic [1:0]  req_vld, rsp_rdy;
  logic [31:0] req_a    [2];
  logic [31:0] req_b    [2];
  logic [1:0]  req_opc  [2];
  logic [1:0]  req_prec [2];

  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];
  logic [CW-1:0] occ_q [2];
  logic [CW-1:0] occ_d [2];
  logic [PW-1:0] wr_q  [2];
  logic [PW-1:0] wr_d  [2];
  logic [PW-1:0] rd_q  [2];
  logic [PW-1:0] rd_d  [2];
  logic [31:0]   mem_q [2][RSP_DEPTH];

  logic [MUL_LATENCY-1:0] tag_vld_q, tag_vld_d, tag_id_q, tag_id_d;
  logic [31:0] opa_q, opa_d, opb_q, opb_d;
  logic [1:0]  opc_q, opc_d, prec_q, prec_d;
  logic [1:0]  elig, gnt, push, pop, nempty;
  logic        gnt_id;
`ifndef MUL_ARB_FIXED_PRIO_EN
  logic        rr_q, rr_d;
`endif

  always_comb begin
    req_vld     = {bus.req1_valid, bus.req0_valid};
    rsp_rdy     = {bus.rsp1_ready, bus.rsp0_ready};
    req_a[0]    = bus.req0_a;
    req_a[1]    = bus.req1_a;
    req_b[0]    = bus.req0_b;
    req_b[1]    = bus.req1_b;
    req_opc[0]  = bus.req0_opcode;
    req_opc[1]  = bus.req1_opcode;
    req_prec[0] = bus.req0_precision;
    req_prec[1] = bus.req1_precision;
  end

  // A pop in the same cycle returns its credit immediately, so a requester
  // whose results are drained every cycle can keep issuing back-to-back.
  always_comb begin
    push[0] = tag_vld_q[MUL_LATENCY-1] & ~tag_id_q[MUL_LATENCY-1];
    push[1] = tag_vld_q[MUL_LATENCY-1] &  tag_id_q[MUL_LATENCY-1];
    for (int k = 0; k < 2; k++) begin
      nempty[k] = (occ_q[k] != '0);
      pop[k]    = nempty[k] & rsp_rdy[k];
      elig[k]   = rst & req_vld[k] & ((cnt_q[k] < DEPTH_C) | pop[k]);
    end
`ifdef MUL_ARB_FIXED_PRIO_EN
    gnt = {elig[1] & ~elig[0], elig[0]};
`else
    gnt = (elig == 2'b11) ? (rr_q ? 2'b10 : 2'b01) : elig;
    rr_d = (|gnt) ? gnt[0] : rr_q;
`endif
    gnt_id = gnt[1];
  end

  always_comb begin
    opa_d  = opa_q;
    opb_d  = opb_q;
    opc_d  = opc_q;
    prec_d = prec_q;
    if (|gnt) begin
      opa_d  = req_a[gnt_id];
      opb_d  = req_b[gnt_id];
      opc_d  = req_opc[gnt_id];
      prec_d = req_prec[gnt_id];
    end
    tag_vld_d    = tag_vld_q;
    tag_id_d     = tag_id_q;
    tag_vld_d[0] = |gnt;
    tag_id_d[0]  = gnt_id;
    for (int i = 1; i < MUL_LATENCY; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_id_d[i]  = tag_id_q[i-1];
    end
    for (int k = 0; k < 2; k++) begin
      cnt_d[k] = cnt_q[k] + CW'(gnt[k]) - CW'(pop[k]);
      occ_d[k] = occ_q[k] + CW'(push[k]) - CW'(pop[k]);
      wr_d[k]  = push[k] ? ptr_inc(wr_q[k]) : wr_q[k];
      rd_d[k]  = pop[k]  ? ptr_inc(rd_q[k]) : rd_q[k];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tag_vld_q <= '0;
      tag_id_q  <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      opc_q     <= '0;
      prec_q    <= '0;
`ifndef MUL_ARB_FIXED_PRIO_EN
      rr_q      <= 1'b0;
`endif
      for (int k = 0; k < 2; k++) begin
        cnt_q[k] <= '0;
        occ_q[k] <= '0;
        wr_q[k]  <= '0;
        rd_q[k]  <= '0;
      end
    end else begin
      tag_vld_q <= tag_vld_d;
      tag_id_q  <= tag_id_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      opc_q     <= opc_d;
      prec_q    <= prec_d;
`ifndef MUL_ARB_FIXED_PRIO_EN
      rr_q      <= rr_d;
`endif
      for (int k = 0; k < 2; k++) begin
        cnt_q[k] <= cnt_d[k];
        occ_q[k] <= occ_d[k];
        wr_q[k]  <= wr_d[k];
        rd_q[k]  <= rd_d[k];
      end
    end
  end

  // Result storage carries no reset; visibility is governed by the pointers.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (push[k]) mem_q[k][wr_q[k]] <= bus.mul_result;
    end
  end

  assign bus.req0_ready    = gnt[0];
  assign bus.req1_ready    = gnt[1];
  assign bus.rsp0_valid    = nempty[0];
  assign bus.rsp1_valid    = nempty[1];
  assign bus.rsp0_data     = nempty[0] ? mem_q[0][rd_q[0]] : '0;
  assign bus.rsp1_data     = nempty[1] ? mem_q[1][rd_q[1]] : '0;
  assign bus.mul_operand_a = opa_q;
  assign bus.mul_operand_b = opb_q;
  assign bus.mul_opcode    = opc_q;
  assign bus.mul_precision = prec_q;
  assign bus.busy          = (|tag_vld_q) | (|nempty);
endmodule
